// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   imem_state_t     - responder FSM state encoding (2-bit)
//   IMEM_OOR_WORD    - default word served for addresses beyond the array
//   IMEM_LATENCY_MAX - largest supported request-to-ready latency
//   IMEM_CNT_W       - width of the wait counter, sized for IMEM_LATENCY_MAX
//   word_oor()       - true when a byte address falls outside a DEPTH-word array
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } imem_state_t;

  // RISC-V NOP (addi x0, x0, 0): harmless if fetched from a hole.
  localparam logic [31:0] IMEM_OOR_WORD    = 32'h0000_0013;
  localparam int          IMEM_LATENCY_MAX = 255;
  localparam int          IMEM_CNT_W       = $clog2(IMEM_LATENCY_MAX + 1);

  // Word address = byte address with the two byte-lane bits dropped.
  function automatic logic word_oor(input logic [31:0] byte_addr,
                                    input int unsigned depth);
    logic [31:0] word_addr;
    word_addr = byte_addr >> 2;
    return (word_addr >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Program word store: synchronous-read, separately addressed write, read-before-write.
// Latency: read data appears one clk after i_rd_en; writes land on the strobe edge.
// Backpressure: none; one read and one write may be issued every cycle.
//
// Ports:
//   clk, reset       - clock; reset clears only the read-data register, never the array
//   i_rd_en/i_rd_idx - read strobe and word index
//   o_rd_dat         - registered read data (holds until the next read)
//   i_wr_en/i_wr_idx/i_wr_dat - write strobe, word index and data
module imem_array #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [31:0]              o_rd_dat,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
  input  logic [31:0]              i_wr_dat
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_dat;

  // Array kept in its own reset-free process so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_dat;
    end
  end

  // Non-blocking read of r_mem sees the pre-edge contents, so a same-edge
  // write to the same index returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the fetch controller: one 32-bit word per request.
// Latency: accept at edge k -> mem_req_ready pulses during cycle k+LATENCY.
// Backpressure: one request outstanding; valid ignored until it drops after the response.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   mem_req_valid/addr         - fetch request (byte address, bits [1:0] ignored)
//   mem_req_ready/rdata        - one-cycle response pulse with its word
//   load_valid/addr/data       - program-load write port, usable in every state
//   busy                       - FSM is not idle
//   resp_count                 - responses delivered (wraps)
//   oor_count                  - out-of-range responses delivered (saturates)
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 4096,
  parameter int          LATENCY  = 4,
  parameter logic [31:0] OOR_WORD = IMEM_OOR_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_req_addr,
  output logic        mem_req_ready,
  output logic [31:0] mem_req_rdata,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic [31:0] resp_count,
  output logic [15:0] oor_count
);

  localparam int                    AW      = $clog2(DEPTH);
  localparam bit                    LAT_ONE = (LATENCY == 1);
  localparam logic [IMEM_CNT_W-1:0] LAT_M1  = IMEM_CNT_W'(LATENCY - 1);

  imem_state_t           r_state;
  logic [AW-1:0]         r_idx;
  logic                  r_oor;
  logic [IMEM_CNT_W-1:0] r_cnt;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_oor_resp;
  logic [31:0]           r_resp_count;
  logic [15:0]           r_oor_count;

  logic                  w_req_oor;
  logic [AW-1:0]         w_req_idx;
  logic                  w_accept;
  logic                  w_wait_done;
  logic                  w_cap;
  logic                  w_cap_oor;
  logic [AW-1:0]         w_rd_idx;
  logic                  w_ld_en;
  logic [AW-1:0]         w_ld_idx;
  logic [31:0]           w_ram_dat;

  assign w_req_oor   = word_oor(mem_req_addr, DEPTH);
  assign w_req_idx   = mem_req_addr[2 +: AW];
  assign w_accept    = (r_state == ST_IDLE) && mem_req_valid;
  assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == IMEM_CNT_W'(1));

  // w_cap marks the edge that enters RESP: the word is captured there and
  // the ready pulse, counters and output select are all updated together.
  // With LATENCY=1 that edge is the accept edge itself, so the RAM is
  // addressed straight from the request bus while idle.
  assign w_cap     = (w_accept && LAT_ONE) || w_wait_done;
  assign w_cap_oor = (r_state == ST_IDLE) ? w_req_oor : r_oor;
  assign w_rd_idx  = (r_state == ST_IDLE) ? w_req_idx : r_idx;

  // Out-of-range loads are dropped; otherwise their low index bits would
  // alias onto a real word.
  assign w_ld_en  = load_valid && !word_oor(load_addr, DEPTH);
  assign w_ld_idx = load_addr[2 +: AW];

  imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .i_rd_en  (w_cap),
    .i_rd_idx (w_rd_idx),
    .o_rd_dat (w_ram_dat),
    .i_wr_en  (w_ld_en),
    .i_wr_idx (w_ld_idx),
    .i_wr_dat (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_oor        <= 1'b0;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_oor_resp   <= 1'b0;
      r_resp_count <= '0;
      r_oor_count  <= '0;
    end else begin
      r_ready <= 1'b0;

      if (w_cap) begin
        r_ready      <= 1'b1;
        r_oor_resp   <= w_cap_oor;
        r_resp_count <= r_resp_count + 32'd1;
        if (w_cap_oor && (r_oor_count != 16'hFFFF)) begin
          r_oor_count <= r_oor_count + 16'd1;
        end
      end

      unique case (r_state)
        ST_IDLE: begin
          if (mem_req_valid) begin
            r_idx   <= w_req_idx;
            r_oor   <= w_req_oor;
            r_cnt   <= LAT_M1;
            r_busy  <= 1'b1;
            r_state <= LAT_ONE ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Runs to completion even if valid drops meanwhile.
          r_cnt <= r_cnt - IMEM_CNT_W'(1);
          if (r_cnt == IMEM_CNT_W'(1)) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Controller still holds valid during RESP; wait for it to drop
          // so the same request is not accepted twice.
          if (!mem_req_valid) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Select and RAM data are both registers; no input reaches an output
  // without passing a flop.
  assign mem_req_rdata = r_oor_resp ? OOR_WORD : w_ram_dat;
  assign mem_req_ready = r_ready;
  assign busy          = r_busy;
  assign resp_count    = r_resp_count;
  assign oor_count     = r_oor_count;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: three responders (LATENCY 4 / 1 / 6), expected words and
// expected ready cycles queued at issue time, popped by per-DUT monitors.
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;

  // DUT A: LATENCY=4, DEPTH=4096
  logic        a_reset, a_valid, a_ready, a_ld_v, a_busy;
  logic [31:0] a_addr, a_rdata, a_ld_addr, a_ld_data, a_resp_cnt;
  logic [15:0] a_oor_cnt;

  // DUTs B (LATENCY=1) and C (LATENCY=6) share one stimulus set, DEPTH=64
  logic        s_reset, s_valid, s_ld_v;
  logic [31:0] s_addr, s_ld_addr, s_ld_data;
  logic        b_ready, b_busy, c_ready, c_busy;
  logic [31:0] b_rdata, b_resp_cnt, c_rdata, c_resp_cnt;
  logic [15:0] b_oor_cnt, c_oor_cnt;

  imem_responder #(.DEPTH(4096), .LATENCY(4)) u_a (
    .clk(clk), .reset(a_reset), .mem_req_valid(a_valid), .mem_req_addr(a_addr),
    .mem_req_ready(a_ready), .mem_req_rdata(a_rdata), .load_valid(a_ld_v),
    .load_addr(a_ld_addr), .load_data(a_ld_data), .busy(a_busy),
    .resp_count(a_resp_cnt), .oor_count(a_oor_cnt));

  imem_responder #(.DEPTH(64), .LATENCY(1)) u_b (
    .clk(clk), .reset(s_reset), .mem_req_valid(s_valid), .mem_req_addr(s_addr),
    .mem_req_ready(b_ready), .mem_req_rdata(b_rdata), .load_valid(s_ld_v),
    .load_addr(s_ld_addr), .load_data(s_ld_data), .busy(b_busy),
    .resp_count(b_resp_cnt), .oor_count(b_oor_cnt));

  imem_responder #(.DEPTH(64), .LATENCY(6)) u_c (
    .clk(clk), .reset(s_reset), .mem_req_valid(s_valid), .mem_req_addr(s_addr),
    .mem_req_ready(c_ready), .mem_req_rdata(c_rdata), .load_valid(s_ld_v),
    .load_addr(s_ld_addr), .load_data(s_ld_data), .busy(c_busy),
    .resp_count(c_resp_cnt), .oor_count(c_oor_cnt));

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got ready=1 expected no response pending (cyc %0d)", name, cyc);
  endtask

  // Monitors: a ready seen at the negedge with count c belongs to cycle c+1.
  always @(negedge clk) begin
    if (a_ready === 1'b1) begin
      if (q_a.size() == 0) unexpected("a_unexpected_ready");
      else begin
        e_a = q_a.pop_front();
        check32("a_rdata", a_rdata, e_a.data);
        check32("a_ready_cycle", cyc + 1, e_a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (b_ready === 1'b1) begin
      if (q_b.size() == 0) unexpected("b_unexpected_ready");
      else begin
        e_b = q_b.pop_front();
        check32("b_rdata", b_rdata, e_b.data);
        check32("b_ready_cycle", cyc + 1, e_b.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (c_ready === 1'b1) begin
      if (q_c.size() == 0) unexpected("c_unexpected_ready");
      else begin
        e_c = q_c.pop_front();
        check32("c_rdata", c_rdata, e_c.data);
        check32("c_ready_cycle", cyc + 1, e_c.cyc);
      end
    end
  end

  task automatic a_load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    a_ld_v = 1'b1; a_ld_addr = addr; a_ld_data = data;
    @(negedge clk);
    a_ld_v = 1'b0;
  endtask

  task automatic s_load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    s_ld_v = 1'b1; s_ld_addr = addr; s_ld_data = data;
    @(negedge clk);
    s_ld_v = 1'b0;
  endtask

  // Controller-style read on DUT A: valid held through the ready cycle,
  // dropped for one cycle after it. Address bus scrambled once accepted.
  // Optional load issued in the interval before the WAIT->RESP edge.
  task automatic a_read(input logic [31:0] addr, input logic [31:0] want,
                        input bit ld, input logic [31:0] ld_addr, input logic [31:0] ld_data);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    a_valid = 1'b1;
    a_addr  = addr;
    q_a.push_back('{want, cyc + 1 + 4});
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) a_addr = 32'hFFFF_FFFC;
      a_ld_v = ld && (i == 3);
      if (i == 3) begin
        a_ld_addr = ld_addr;
        a_ld_data = ld_data;
      end
      if (a_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL a_read_timeout: got no ready expected ready for addr %h", addr);
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_ld_v  = 1'b0;
  endtask

  // Shared request to B and C; valid held for 'hold' cycles.
  task automatic s_req(input logic [31:0] addr, input logic [31:0] want, input int hold);
    @(negedge clk);
    s_valid = 1'b1;
    s_addr  = addr;
    q_b.push_back('{want, cyc + 1 + 1});
    q_c.push_back('{want, cyc + 1 + 6});
    repeat (hold) @(negedge clk);
    s_valid = 1'b0;
    s_addr  = 32'h0000_03FC;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    a_reset = 1'b1; a_valid = 1'b0; a_addr = '0; a_ld_v = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    s_reset = 1'b1; s_valid = 1'b0; s_addr = '0; s_ld_v = 1'b0; s_ld_addr = '0; s_ld_data = '0;
    repeat (3) @(negedge clk);
    a_reset = 1'b0;
    s_reset = 1'b0;

    check32("rst_ready", {31'd0, a_ready}, 32'd0);
    check32("rst_rdata", a_rdata, 32'd0);
    check32("rst_busy", {31'd0, a_busy}, 32'd0);
    check32("rst_resp_count", a_resp_cnt, 32'd0);
    check32("rst_oor_count", {16'd0, a_oor_cnt}, 32'd0);

    a_load(32'h14, 32'hDEAD_BEEF);
    a_load(32'h40, 32'h0101_0101);
    a_load(32'h44, 32'h0202_0202);
    a_load(32'h48, 32'h0303_0303);
    a_load(32'h4C, 32'h0404_0404);
    a_load(32'h20, 32'hAAAA_AAAA);
    a_load(32'h00, 32'hCAFE_F00D);

    // Basic read
    a_read(32'h14, 32'hDEAD_BEEF, 1'b0, '0, '0);
    check32("basic_resp_count", a_resp_cnt, 32'd1);
    check32("basic_oor_count", {16'd0, a_oor_cnt}, 32'd0);

    // Burst, back-to-back at LATENCY+2 spacing
    for (int w = 0; w < 4; w++) begin
      a_read(32'h40 + 32'(4 * w), {4{8'(w + 1)}}, 1'b0, '0, '0);
    end
    check32("burst_resp_count", a_resp_cnt, 32'd5);

    // Out of range read and load
    a_read(32'h0000_4000, 32'h0000_0013, 1'b0, '0, '0);
    check32("oor_count", {16'd0, a_oor_cnt}, 32'd1);
    a_load(32'h0000_4000, 32'h1234_5678);
    a_read(32'h0000_0000, 32'hCAFE_F00D, 1'b0, '0, '0);

    // Same-edge load on WAIT->RESP edge returns old word
    a_read(32'h20, 32'hAAAA_AAAA, 1'b1, 32'h20, 32'h1111_1111);
    a_read(32'h20, 32'h1111_1111, 1'b0, '0, '0);
    check32("pre_reset_resp_count", a_resp_cnt, 32'd9);
    check32("pre_reset_oor_count", {16'd0, a_oor_cnt}, 32'd1);

    // Reset during WAIT: accept at edge k, reset sampled at edge k+2
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h14;
    @(negedge clk);
    a_addr = 32'h0;
    @(negedge clk);
    check32("wait_busy", {31'd0, a_busy}, 32'd1);
    a_reset = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    a_reset = 1'b0;
    check32("mid_reset_busy", {31'd0, a_busy}, 32'd0);
    check32("mid_reset_ready", {31'd0, a_ready}, 32'd0);
    check32("mid_reset_resp_count", a_resp_cnt, 32'd0);
    check32("mid_reset_oor_count", {16'd0, a_oor_cnt}, 32'd0);
    repeat (8) @(negedge clk);
    a_read(32'h14, 32'hDEAD_BEEF, 1'b0, '0, '0);
    a_read(32'h20, 32'h1111_1111, 1'b0, '0, '0);
    check32("post_reset_resp_count", a_resp_cnt, 32'd2);

    // LATENCY=1 (B) and LATENCY=6 (C); valid drops mid-WAIT on C
    s_load(32'h0C, 32'h0BAD_F00D);
    s_load(32'h1C, 32'h7777_7777);
    s_req(32'h0C, 32'h0BAD_F00D, 1);
    s_req(32'h1C, 32'h7777_7777, 2);
    s_req(32'h100, 32'h0000_0013, 1);
    check32("b_resp_count", b_resp_cnt, 32'd3);
    check32("c_resp_count", c_resp_cnt, 32'd3);
    check32("b_oor_count", {16'd0, b_oor_cnt}, 32'd1);
    check32("c_oor_count", {16'd0, c_oor_cnt}, 32'd1);
    check32("b_busy_end", {31'd0, b_busy}, 32'd0);
    check32("c_busy_end", {31'd0, c_busy}, 32'd0);

    repeat (4) @(negedge clk);
    check32("a_missing_responses", q_a.size(), 32'd0);
    check32("b_missing_responses", q_b.size(), 32'd0);
    check32("c_missing_responses", q_c.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
